// File: rtl/seg7_pkg.sv
// seg7_pkg: definitions shared by the seven-segment encoder and decoder.
//   SEG_BLANK - all-segments-off pattern (active-low bus, so all ones)
//   GLYPHS    - active-low glyph for each nibble; bit0=a .. bit6=g.
//               The encoder and decoder both index this one table,
//               so the two directions always agree.
//   state_t   - state of the bus decoder stability filter
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPHS [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: combinational inverse of the hex-to-7-segment table.
//   segs   in  7  active-low segment pattern, bit0=a .. bit6=g
//   nibble out 4  decoded hex value (0 when blank or not a glyph)
//   blank  out 1  pattern is all segments off
//   err    out 1  pattern is neither a glyph nor blank
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] segs,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  logic found;

  always_comb begin
    nibble = 4'd0;
    found  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (segs == GLYPHS[i]) begin
        nibble = 4'(i);
        found  = 1'b1;
      end
    end
    blank = (segs == SEG_BLANK);
    err   = !found && !blank;
  end

endmodule

// File: rtl/seg7_bus_decoder.sv
// seg7_bus_decoder: monitors a multiplexed active-low seven-segment bus.
// A pattern {segs,dig_sel} must be seen unchanged for STABLE_CYCLES
// consecutive samples before it is captured; each capture for a single
// selected digit is decoded, published on the upd_* channel and stored
// in the per-digit shadow.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   segs         segment lines, active-low, bit0=a .. bit6=g
//   dig_sel      digit enables, active-low one-hot (all ones = none)
//   upd_valid    update pending
//   upd_ready    consumer accepts
//   upd_idx      digit index of the update
//   upd_nibble   decoded value (0 for blank or invalid)
//   upd_blank    captured pattern was blank
//   upd_err      captured pattern was not a legal glyph
//   digit_vals   shadow nibbles, digit i at [4i+3:4i]
//   digit_blank  per-digit blank flags
//   sel_err      sticky: stable pattern with several digits selected
//   ovf          sticky: capture overwrote an unaccepted update
//   dbg_state    current filter state (state_t encoding)
//
// Handshake: an update is offered while upd_valid=1 and its fields hold
// steady until a rising edge with upd_valid && upd_ready, which consumes
// it. A capture on that same edge loads the next update and keeps
// upd_valid high without flagging overflow.
module seg7_bus_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              segs,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    upd_valid,
  input  logic                    upd_ready,
  output logic [IDX_W-1:0]        upd_idx,
  output logic [3:0]              upd_nibble,
  output logic                    upd_blank,
  output logic                    upd_err,
  output logic [4*NUM_DIGITS-1:0] digit_vals,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    sel_err,
  output logic                    ovf,
  output logic [1:0]              dbg_state
);

  localparam int SW = 7 + NUM_DIGITS;

  // Sample register and stability filter
  logic [SW-1:0]    s_q;
  logic             match;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic             capture;

  assign match     = ({segs, dig_sel} == s_q);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= '1;
      state_q    <= IDLE;
      stab_cnt_q <= '0;
    end else begin
      s_q        <= {segs, dig_sel};
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    capture    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!match) begin
          state_d    = SETTLE;
          stab_cnt_d = CNT_W'(1);
        end
      end
      SETTLE: begin
        if (!match) begin
          stab_cnt_d = CNT_W'(1);
        end else if (stab_cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          capture = 1'b1;
          state_d = HELD;
        end else begin
          stab_cnt_d = stab_cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!match) begin
          state_d    = SETTLE;
          stab_cnt_d = CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        stab_cnt_d = '0;
      end
    endcase
  end

  // Decode of the held (stable) pattern; s_q equals the inputs whenever
  // a capture fires, since capture requires match.
  logic [6:0]            cap_segs;
  logic [NUM_DIGITS-1:0] cap_sel;
  logic [3:0]            dec_nibble;
  logic                  dec_blank;
  logic                  dec_err;

  assign cap_segs = s_q[SW-1:NUM_DIGITS];
  assign cap_sel  = s_q[NUM_DIGITS-1:0];

  seg7_glyph_decode u_glyph (
    .segs   (cap_segs),
    .nibble (dec_nibble),
    .blank  (dec_blank),
    .err    (dec_err)
  );

  // Digit-select classification: count selected (low) lines, remember index
  logic [IDX_W-1:0] sel_idx;
  int unsigned      sel_cnt;
  logic             sel_one;
  logic             sel_multi;

  always_comb begin
    sel_idx = '0;
    sel_cnt = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!cap_sel[i]) begin
        sel_idx = IDX_W'(i);
        sel_cnt = sel_cnt + 1;
      end
    end
    sel_one   = (sel_cnt == 1);
    sel_multi = (sel_cnt > 1);
  end

  logic load;
  assign load = capture && sel_one;

  // Update channel, shadow registers and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid   <= 1'b0;
      upd_idx     <= '0;
      upd_nibble  <= 4'd0;
      upd_blank   <= 1'b0;
      upd_err     <= 1'b0;
      digit_vals  <= '0;
      digit_blank <= '1;
      sel_err     <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      if (load) begin
        upd_valid  <= 1'b1;
        upd_idx    <= sel_idx;
        upd_nibble <= dec_nibble;
        upd_blank  <= dec_blank;
        upd_err    <= dec_err;
        if (upd_valid && !upd_ready) begin
          ovf <= 1'b1;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (IDX_W'(i) == sel_idx) begin
            digit_blank[i] <= dec_blank;
            if (!dec_err) begin
              digit_vals[4*i +: 4] <= dec_nibble;
            end
          end
        end
      end else if (upd_valid && upd_ready) begin
        upd_valid <= 1'b0;
      end
      if (capture && sel_multi) begin
        sel_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_bus_decoder.sv
// Bench for seg7_bus_decoder: directed bus patterns with hand-computed
// expectations. Every issued pattern that should produce an update pushes
// {idx, nibble, blank, err} into exp_q; a monitor pops and compares each
// update at the moment it is accepted.
module tb_seg7_bus_decoder;

  localparam int ND = 6;
  localparam int W  = 3 + 4 + 1 + 1;

  logic          clk;
  logic          rst_n;
  logic [6:0]    segs;
  logic [ND-1:0] dig_sel;
  logic          upd_valid;
  logic          upd_ready;
  logic [2:0]    upd_idx;
  logic [3:0]    upd_nibble;
  logic          upd_blank;
  logic          upd_err;
  logic [4*ND-1:0] digit_vals;
  logic [ND-1:0] digit_blank;
  logic          sel_err;
  logic          ovf;
  logic [1:0]    dbg_state;

  seg7_bus_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .segs        (segs),
    .dig_sel     (dig_sel),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_idx     (upd_idx),
    .upd_nibble  (upd_nibble),
    .upd_blank   (upd_blank),
    .upd_err     (upd_err),
    .digit_vals  (digit_vals),
    .digit_blank (digit_blank),
    .sel_err     (sel_err),
    .ovf         (ovf),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int pops  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: an update is consumed at the next rising edge when valid&&ready
  // are both high at the falling edge (inputs only change just after rising).
  always @(negedge clk) begin
    if (rst_n && upd_valid && upd_ready) begin
      logic [W-1:0] exp;
      total++;
      pops++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_update: got %0h expected none",
                 {upd_idx, upd_nibble, upd_blank, upd_err});
      end else begin
        exp = exp_q.pop_front();
        if ({upd_idx, upd_nibble, upd_blank, upd_err} !== exp) begin
          bad++;
          $display("FAIL update: got idx=%0d nib=%0h blank=%0b err=%0b expected idx=%0d nib=%0h blank=%0b err=%0b",
                   upd_idx, upd_nibble, upd_blank, upd_err,
                   exp[8:6], exp[5:2], exp[1], exp[0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic present(input logic [6:0] s, input logic [ND-1:0] d, input int hold);
    segs    = s;
    dig_sel = d;
    step(hold);
  endtask

  task automatic expect_upd(input int idx, input int nib, input bit blank, input bit err);
    exp_q.push_back({3'(idx), 4'(nib), blank, err});
  endtask

  task automatic accept();
    upd_ready = 1'b1;
    step(1);
    upd_ready = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 32'(upd_valid), 32'd0);
    check({tag, "_vals"}, 32'(digit_vals), 32'd0);
    check({tag, "_blank"}, 32'(digit_blank), 32'h3F);
    check({tag, "_selerr"}, 32'(sel_err), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  logic [6:0] glyph_tb [0:5];

  initial begin
    glyph_tb[0] = 7'b1000000;
    glyph_tb[1] = 7'b1111001;
    glyph_tb[2] = 7'b0100100;
    glyph_tb[3] = 7'b0110000;
    glyph_tb[4] = 7'b0011001;
    glyph_tb[5] = 7'b0010010;

    rst_n     = 1'b1;
    segs      = 7'h7F;
    dig_sel   = '1;
    upd_ready = 1'b0;
    #1 rst_n = 1'b0;
    #10;
    check_reset("reset");
    check("reset_idx", 32'(upd_idx), 32'd0);
    check("reset_nib", 32'(upd_nibble), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // Stable capture of '2' on digit 0
    expect_upd(0, 2, 0, 0);
    present(7'b0100100, 6'b111110, 3);
    check("cap_not_early", 32'(upd_valid), 32'd0);
    step(1);
    check("cap_valid", 32'(upd_valid), 32'd1);
    check("cap_idx", 32'(upd_idx), 32'd0);
    check("cap_nib", 32'(upd_nibble), 32'd2);
    check("cap_shadow", 32'(digit_vals[3:0]), 32'd2);
    check("cap_dblank", 32'(digit_blank[0]), 32'd0);
    step(3);
    check("cap_hold", 32'(upd_valid), 32'd1);
    accept();
    check("cap_cleared", 32'(upd_valid), 32'd0);

    // Glitch rejection: 'A' for 2 cycles, then 'b' on digit 2
    present(7'b0001000, 6'b111011, 2);
    check("glitch_none", 32'(upd_valid), 32'd0);
    expect_upd(2, 11, 0, 0);
    present(7'b0000011, 6'b111011, 3);
    check("glitch_restart", 32'(upd_valid), 32'd0);
    step(1);
    check("glitch_valid", 32'(upd_valid), 32'd1);
    check("glitch_shadow", 32'(digit_vals[11:8]), 32'hB);
    accept();

    // Invalid glyph and blank on digit 1 (after showing '7')
    expect_upd(1, 7, 0, 0);
    present(7'b1111000, 6'b111101, 4);
    accept();
    expect_upd(1, 0, 0, 1);
    present(7'b1010101, 6'b111101, 4);
    check("err_flag", 32'(upd_err), 32'd1);
    check("err_nib", 32'(upd_nibble), 32'd0);
    check("err_shadow_kept", 32'(digit_vals[7:4]), 32'd7);
    accept();
    expect_upd(1, 0, 1, 0);
    present(7'b1111111, 6'b111101, 4);
    check("blank_flag", 32'(upd_blank), 32'd1);
    check("blank_dblank", 32'(digit_blank[1]), 32'd1);
    accept();

    // Select error, then no digit selected
    present(7'b1000000, 6'b111100, 4);
    check("selerr_flag", 32'(sel_err), 32'd1);
    check("selerr_noupd", 32'(upd_valid), 32'd0);
    present(7'b1000000, 6'b111111, 6);
    check("idle_noupd", 32'(upd_valid), 32'd0);
    check("idle_vals", 32'(digit_vals), 32'h000B02);

    // Overflow: second capture overwrites an unaccepted update
    present(7'b1111001, 6'b111110, 4);
    check("ovf_first", 32'(upd_valid), 32'd1);
    expect_upd(3, 4, 0, 0);
    present(7'b0011001, 6'b110111, 4);
    check("ovf_flag", 32'(ovf), 32'd1);
    check("ovf_idx", 32'(upd_idx), 32'd3);
    accept();

    // Reset, then capture coinciding with acceptance
    segs    = 7'h7F;
    dig_sel = '1;
    rst_n   = 1'b0;
    #3;
    check_reset("reset2");
    step(1);
    rst_n = 1'b1;
    step(1);
    expect_upd(0, 1, 0, 0);
    present(7'b1111001, 6'b111110, 4);
    expect_upd(3, 4, 0, 0);
    present(7'b0011001, 6'b110111, 3);
    upd_ready = 1'b1;
    step(1);
    upd_ready = 1'b0;
    check("simul_ovf", 32'(ovf), 32'd0);
    check("simul_valid", 32'(upd_valid), 32'd1);
    check("simul_idx", 32'(upd_idx), 32'd3);
    accept();

    // Scan sweep: digits 0..5 show 0..5, consumer always ready
    begin
      int p0;
      p0 = pops;
      upd_ready = 1'b1;
      for (int d = 0; d < ND; d++) begin
        expect_upd(d, d, 0, 0);
        present(glyph_tb[d], ~(6'(1) << d), 10);
      end
      upd_ready = 1'b0;
      check("sweep_updates", 32'(pops - p0), 32'd6);
      check("sweep_vals", 32'(digit_vals), 32'h543210);
      check("sweep_dblank", 32'(digit_blank), 32'h00);
    end

    // Reset while settling on a new pattern
    present(7'b0000000, 6'b111110, 2);
    check("settle_state", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset("reset3");
    segs    = 7'h7F;
    dig_sel = '1;
    step(1);
    rst_n = 1'b1;
    step(2);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
